// File: rtl/led_blink_reporter_if.sv
// led_blink_reporter_if: request/status bundle between a count source and the
// blink reporter. The 'repeat_req' signal exists only when LED_BLINK_REPEAT_EN
// is defined ('repeat' itself is a reserved word).
`timescale 1ns/1ps

interface led_blink_reporter_if #(
    parameter int unsigned WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] value;
`ifdef LED_BLINK_REPEAT_EN
    logic             repeat_req;
`endif
    logic             led;
    logic             busy;
    logic             done;

    // Count source / test driver side
    modport master (
        output start,
        output value,
`ifdef LED_BLINK_REPEAT_EN
        output repeat_req,
`endif
        input  led,
        input  busy,
        input  done
    );

    // Reporter side
    modport slave (
        input  start,
        input  value,
`ifdef LED_BLINK_REPEAT_EN
        input  repeat_req,
`endif
        output led,
        output busy,
        output done
    );
endinterface

// File: rtl/led_blink_reporter.sv
// led_blink_reporter: shows a latched count N as N LED blinks followed by an
// off gap, then pulses done. All outputs are registered.
// Optional macro LED_BLINK_REPEAT_EN: when repeat_req is high in the last gap
// cycle, the current value is re-latched and a new report starts at once.
`timescale 1ns/1ps

module led_blink_reporter #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned ON_CYCLES  = 25000000,
    parameter int unsigned OFF_CYCLES = 25000000,
    parameter int unsigned GAP_CYCLES = 100000000
) (
    input logic                 clk,
    input logic                 rst,
    led_blink_reporter_if.slave bus
);

    localparam int unsigned MAX_ON_OFF = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int unsigned MAX_CYC    = (MAX_ON_OFF > GAP_CYCLES) ? MAX_ON_OFF : GAP_CYCLES;
    localparam int unsigned TW         = $clog2(MAX_CYC + 1);

    // Timer counts down to zero, so each phase loads its length minus one
    localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LOAD = TW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ON,
        S_OFF,
        S_GAP
    } state_t;

    state_t           r_state;
    logic [TW-1:0]    r_timer;
    logic [WIDTH-1:0] r_cnt;
    logic             r_led;
    logic             r_busy;
    logic             r_done;

    logic             w_timer_zero;
    logic             w_last_blink;
    logic             w_repeat;
    state_t           w_first_state;
    logic [TW-1:0]    w_first_timer;
    logic             w_first_led;

    assign w_timer_zero = (r_timer == '0);
    assign w_last_blink = (r_cnt == WIDTH'(1));

`ifdef LED_BLINK_REPEAT_EN
    assign w_repeat = bus.repeat_req;
`else
    assign w_repeat = 1'b0;
`endif

    // First phase of a report: blinking if there is anything to show, else straight to the gap
    always_comb begin
        w_first_state = S_GAP;
        w_first_timer = GAP_LOAD;
        w_first_led   = 1'b0;
        if (bus.value != '0) begin
            w_first_state = S_ON;
            w_first_timer = ON_LOAD;
            w_first_led   = 1'b1;
        end
    end

    // Report sequencer: IDLE -> (ON -> OFF)* -> ON -> GAP -> IDLE, outputs registered
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            r_cnt   <= '0;
            r_led   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_led  <= 1'b0;
                    r_busy <= 1'b0;
                    if (bus.start) begin
                        r_cnt   <= bus.value;
                        r_busy  <= 1'b1;
                        r_state <= w_first_state;
                        r_timer <= w_first_timer;
                        r_led   <= w_first_led;
                    end
                end
                S_ON: begin
                    if (w_timer_zero) begin
                        r_cnt <= r_cnt - WIDTH'(1);
                        r_led <= 1'b0;
                        if (w_last_blink) begin
                            r_state <= S_GAP;
                            r_timer <= GAP_LOAD;
                        end else begin
                            r_state <= S_OFF;
                            r_timer <= OFF_LOAD;
                        end
                    end else begin
                        r_timer <= r_timer - TW'(1);
                    end
                end
                S_OFF: begin
                    if (w_timer_zero) begin
                        r_state <= S_ON;
                        r_timer <= ON_LOAD;
                        r_led   <= 1'b1;
                    end else begin
                        r_timer <= r_timer - TW'(1);
                    end
                end
                S_GAP: begin
                    if (w_timer_zero) begin
                        r_done <= 1'b1;
                        // A repeat skips IDLE: done pulses while busy stays high
                        if (w_repeat) begin
                            r_cnt   <= bus.value;
                            r_state <= w_first_state;
                            r_timer <= w_first_timer;
                            r_led   <= w_first_led;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_timer <= r_timer - TW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_led   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.led  = r_led;
    assign bus.busy = r_busy;
    assign bus.done = r_done;

endmodule

// File: tb/tb_led_blink_reporter.sv
// tb_led_blink_reporter: scoreboard bench. Stimulus pushes the expected report
// shape (busy length, blink count, lit cycles, lit-position sum) computed from
// the blink/gap timing rules; a monitor measures each report and compares on done.
`timescale 1ns/1ps

module tb_led_blink_reporter;

    localparam int W   = 4;
    localparam int ON  = 2;
    localparam int OFF = 3;
    localparam int GAP = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    led_blink_reporter_if #(.WIDTH(W)) bus ();

    led_blink_reporter #(
        .WIDTH      (W),
        .ON_CYCLES  (ON),
        .OFF_CYCLES (OFF),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        int value;
        int len;
        int rises;
        int lit;
        int chk;
    } rep_t;

    rep_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic void check(string name, int act, int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endfunction

    // Blink k (0-based) is lit at busy positions k*(ON+OFF)+1 .. k*(ON+OFF)+ON
    function automatic rep_t model(int n);
        rep_t r;
        r.value = n;
        r.rises = n;
        r.lit   = n * ON;
        r.len   = (n == 0) ? GAP : n * ON + (n - 1) * OFF + GAP;
        r.chk   = 0;
        for (int k = 0; k < n; k++)
            for (int j = 0; j < ON; j++)
                r.chk += k * (ON + OFF) + j + 1;
        return r;
    endfunction

    // Monitor: measure each report while busy, compare against the scoreboard on done
    initial begin
        int   len, rises, lit, chk;
        logic prev_led, prev_done, prev_rpt, allow;
        rep_t e;
        len = 0; rises = 0; lit = 0; chk = 0;
        prev_led = 1'b0; prev_done = 1'b0; prev_rpt = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                len = 0; rises = 0; lit = 0; chk = 0;
                prev_led = 1'b0; prev_done = 1'b0; prev_rpt = 1'b0;
            end else begin
                check("led_outside_busy", int'(bus.led && !bus.busy), 0);
                if (bus.done) begin
                    check("done_single_cycle", int'(prev_done), 0);
                    allow = prev_rpt;
                    if (!allow) check("done_busy_exclusive", int'(bus.busy), 0);
                    check("done_expected", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check($sformatf("busy_len(v=%0d)", e.value), len, e.len);
                        check($sformatf("blinks(v=%0d)", e.value), rises, e.rises);
                        check($sformatf("lit_cycles(v=%0d)", e.value), lit, e.lit);
                        check($sformatf("led_pattern(v=%0d)", e.value), chk, e.chk);
                    end
                    len = 0; rises = 0; lit = 0; chk = 0;
                end
                if (bus.busy) begin
                    len++;
                    if (bus.led) begin
                        lit++;
                        chk += len;
                        if (!prev_led) rises++;
                    end
                end
                prev_led  = bus.led;
                prev_done = bus.done;
`ifdef LED_BLINK_REPEAT_EN
                prev_rpt  = bus.repeat_req;
`else
                prev_rpt  = 1'b0;
`endif
            end
        end
    end

    task automatic issue(int v);
        @(posedge clk); #1;
        exp_q.push_back(model(v));
        bus.value = W'(v);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(int budget, string tag);
        bit seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(negedge clk);
            seen = bus.done;
        end
        check({tag, "_done_seen"}, int'(seen), 1);
    endtask

    // Pulse start (with a different value) while a report of length len is running
    task automatic noise(int len);
        int d;
        d = $urandom_range(1, len - 2);
        repeat (d) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.value = W'($urandom);
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    // Stimulus
    initial begin
        int rc, dones, v;
        logic pl;

        bus.start = 1'b0;
        bus.value = '0;
`ifdef LED_BLINK_REPEAT_EN
        bus.repeat_req = 1'b0;
`endif
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_led", int'(bus.led), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        @(posedge clk); #1;
        rst = 1'b1;

        issue(3);  wait_done(100, "v3");
        issue(0);  wait_done(100, "v0");
        issue(15); wait_done(200, "v15");

        // start and value change during a report are ignored
        issue(5);
        repeat (4) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.value = W'(7);
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(100, "v5_ignored");

        // start in the done cycle is accepted; busy follows on the next cycle
        exp_q.push_back(model(6));
        bus.value = W'(6);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        check("back_to_back_busy", int'(bus.busy), 1);
        wait_done(100, "v6_b2b");

        // reset during the second blink aborts the report with no done
        issue(3);
        rc = 0; pl = 1'b0;
        for (int c = 0; c < 50 && rc < 2; c++) begin
            @(negedge clk);
            if (bus.led && !pl) rc++;
            pl = bus.led;
        end
        check("second_blink_seen", rc, 2);
        rst = 1'b0;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        check("abort_led", int'(bus.led), 0);
        check("abort_busy", int'(bus.busy), 0);
        check("abort_done", int'(bus.done), 0);
        rst = 1'b1;
        dones = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check("no_done_after_abort", dones, 0);
        issue(3); wait_done(100, "v3_after_abort");

        // randomized reports with random idle gaps and ignored mid-report starts
        for (int t = 0; t < 20; t++) begin
            v = $urandom_range(0, (1 << W) - 1);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            issue(v);
            if ($urandom_range(0, 1) == 1) noise(model(v).len);
            wait_done(200, $sformatf("rand%0d", t));
        end

`ifdef LED_BLINK_REPEAT_EN
        // repeat keeps reporting without idling; dropping it ends in IDLE
        for (int k = 0; k < 4; k++) exp_q.push_back(model(2));
        bus.repeat_req = 1'b1;
        @(posedge clk); #1;
        bus.value = W'(2);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wait_done(50, $sformatf("rpt%0d", k));
            check("rpt_busy_at_done", int'(bus.busy), 1);
        end
        bus.repeat_req = 1'b0;
        wait_done(50, "rpt_last");
        check("rpt_end_idle", int'(bus.busy), 0);
`endif

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
